j17_control_unit: RTL and testbench

//  Multi-cycle controller that sequences the J17 datapath: fetches a 32-bit instruction, decodes it,
//  and drives the datapath control strobes for exactly one commit cycle per instruction.

---
 rtl/j17_pkg.sv | 57 +++++
 rtl/j17_if.sv | 54 +++++
 rtl/j17_decoder.sv | 65 ++++++
 rtl/j17_control_unit.sv | 159 +++++++++++++++
 tb/tb_j17_control_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/j17_pkg.sv
// Shared types and constants for the J17 control unit: state encoding,
// instruction field positions, opcode constants and control-code values.
package j17_pkg;

   localparam int OPC_LSB = 26;
   localparam int OP1_LSB = 21;
   localparam int OP2_LSB = 16;
   localparam int IMM_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LI,
      CLS_BRANCH,
      CLS_LOAD,
      CLS_STORE,
      CLS_HALT
   } iclass_e;

   localparam logic [5:0] OPC_LOAD  = 6'h30;
   localparam logic [5:0] OPC_STORE = 6'h31;
   localparam logic [5:0] OPC_LI    = 6'h32;
   localparam logic [5:0] OPC_HALT  = 6'h3F;

   localparam logic [3:0] ALU_LAST  = 4'd11;

   localparam logic [2:0] PC_NEXT   = 3'd0;
   localparam logic [2:0] PC_JUMP   = 3'd7;

   localparam logic [1:0] WC_ALU    = 2'd0;
   localparam logic [1:0] WC_IMM    = 2'd1;
   localparam logic [1:0] WC_RAM    = 2'd2;

   localparam logic [1:0] RAM_IDLE  = 2'b00;
   localparam logic [1:0] RAM_READ  = 2'b01;
   localparam logic [1:0] RAM_WRITE = 2'b10;

   // Decoded view of one opcode; illegal opcodes carry legal=0 and zeroed fields.
   typedef struct packed {
      logic [4:0] alucode;
      logic       imm;
      logic [2:0] pc_ctl;
      logic [1:0] wcode;
      iclass_e    cls;
      logic       legal;
   } dec_t;

endpackage

// File: rtl/j17_if.sv
// Instruction-fetch, RAM handshake and datapath control bundle of the J17 core.
// master = control unit, slave = instruction memory / RAM / datapath side.
interface j17_if #(parameter int IW = 32);

   logic          imem_req;
   logic          imem_ack;
   logic [IW-1:0] imem_data;
   logic [5:0]    opcode;
   logic [4:0]    op1;
   logic [4:0]    op2;
   logic [4:0]    alucode;
   logic          imControl;
   logic          regenable;
   logic [1:0]    ramenable;
   logic          mem_ready;
   logic [1:0]    writecode;
   logic [2:0]    pcControl;
   logic          pc_en;

   modport master (
      output imem_req,
      input  imem_ack,
      input  imem_data,
      output opcode,
      output op1,
      output op2,
      output alucode,
      output imControl,
      output regenable,
      output ramenable,
      input  mem_ready,
      output writecode,
      output pcControl,
      output pc_en
   );

   modport slave (
      input  imem_req,
      output imem_ack,
      output imem_data,
      input  opcode,
      input  op1,
      input  op2,
      input  alucode,
      input  imControl,
      input  regenable,
      input  ramenable,
      output mem_ready,
      input  writecode,
      input  pcControl,
      input  pc_en
   );

endinterface

// File: rtl/j17_decoder.sv
// Combinational opcode decoder: maps the 6-bit opcode to ALU code, immediate
// select, branch condition, write-back source, instruction class and legality.
module j17_decoder
   import j17_pkg::*;
(
   input  logic [5:0] opc,
   output dec_t       dec
);

   // Opcode groups: 00/01 ALU (reg/imm), 10 branch, 11 memory/LI/HALT.
   always_comb begin
      dec       = '0;
      dec.cls   = CLS_ALU;
      dec.legal = 1'b0;
      case (opc[5:4])
         2'b00, 2'b01: begin
            dec.cls     = CLS_ALU;
            dec.alucode = {1'b0, opc[3:0]};
            dec.imm     = opc[4];
            dec.wcode   = WC_ALU;
            dec.legal   = (opc[3:0] <= ALU_LAST);
         end
         2'b10: begin
            dec.cls    = CLS_BRANCH;
            dec.pc_ctl = opc[2:0];
            dec.legal  = (opc[2:0] != PC_NEXT);
         end
         default: begin
            case (opc)
               OPC_LOAD: begin
                  dec.cls   = CLS_LOAD;
                  dec.wcode = WC_RAM;
                  dec.legal = 1'b1;
               end
               OPC_STORE: begin
                  dec.cls   = CLS_STORE;
                  dec.legal = 1'b1;
               end
               OPC_LI: begin
                  dec.cls   = CLS_LI;
                  dec.wcode = WC_IMM;
                  dec.legal = 1'b1;
               end
               OPC_HALT: begin
                  dec.cls   = CLS_HALT;
                  dec.legal = 1'b1;
               end
               default: begin
                  dec.cls   = CLS_HALT;
                  dec.legal = 1'b0;
               end
            endcase
         end
      endcase
      // Illegal opcodes never drive datapath controls.
      if (!dec.legal) begin
         dec.alucode = '0;
         dec.imm     = 1'b0;
         dec.pc_ctl  = PC_NEXT;
         dec.wcode   = WC_ALU;
         dec.cls     = CLS_HALT;
      end
   end

endmodule

// File: rtl/j17_control_unit.sv
// J17 multi-cycle control unit: fetch handshake, decode, one commit cycle per
// instruction, RAM stall handling, illegal-opcode trap and retired counter.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | paused at instruction boundary, waiting for run
//  FETCH   | imem_req high until imem_ack; instruction latched on ack
//  DECODE  | one cycle; illegal/HALT opcodes divert to HALT
//  EXEC    | commit for ALU/LI/branch; LOAD/STORE go on to MEM
//  MEM     | ramenable held until mem_ready; STORE commits here
//  WB      | LOAD write-back commit
//  HALT    | all strobes low; left only through reset
module j17_control_unit
   import j17_pkg::*;
#(
   parameter int IW    = 32,
   parameter int CNT_W = 32
)(
   input  logic             clock,
   input  logic             resetn,
   input  logic             run,
   j17_if.master            bus,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_e           state_q;
   state_e           state_d;
   logic [5:0]       opc_q;
   logic [4:0]       op1_q;
   logic [4:0]       op2_q;
   dec_t             dec_q;
   dec_t             dec_in;
   logic             illegal_q;
   logic [CNT_W-1:0] instret_q;
   logic             commit;
   logic             set_illegal;
   logic             fetch_done;

   // The immediate field is consumed by the datapath directly, not by control.
   logic             unused_imm;
   assign unused_imm = ^bus.imem_data[IW-OPC_LSB+IMM_W-7:0];

   j17_decoder u_decoder (
      .opc (bus.imem_data[OPC_LSB +: 6]),
      .dec (dec_in)
   );

   assign fetch_done = (state_q == ST_FETCH) && bus.imem_ack;

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake/commit strobes.
   always_comb begin
      state_d       = state_q;
      commit        = 1'b0;
      set_illegal   = 1'b0;
      bus.imem_req  = 1'b0;
      bus.regenable = 1'b0;
      bus.pc_en     = 1'b0;
      bus.ramenable = RAM_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (!dec_q.legal) begin
               state_d     = ST_HALT;
               set_illegal = 1'b1;
            end else if (dec_q.cls == CLS_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (dec_q.cls)
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               CLS_ALU, CLS_LI: begin
                  bus.regenable = 1'b1;
                  commit        = 1'b1;
               end
               CLS_BRANCH: commit  = 1'b1;
               default:    state_d = ST_HALT;
            endcase
         end
         ST_MEM: begin
            bus.ramenable = (dec_q.cls == CLS_LOAD) ? RAM_READ : RAM_WRITE;
            if (bus.mem_ready) begin
               if (dec_q.cls == CLS_LOAD) state_d = ST_WB;
               else                       commit  = 1'b1;
            end
         end
         ST_WB: begin
            bus.regenable = 1'b1;
            commit        = 1'b1;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: state_d = ST_IDLE;
      endcase
      if (commit) begin
         bus.pc_en = 1'b1;
         state_d   = run ? ST_FETCH : ST_IDLE;
      end
   end

   // Instruction register: fields and decode result captured on fetch ack so
   // they are stable from DECODE through the commit cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         opc_q <= '0;
         op1_q <= '0;
         op2_q <= '0;
         dec_q <= '0;
      end else if (fetch_done) begin
         opc_q <= bus.imem_data[OPC_LSB +: 6];
         op1_q <= bus.imem_data[OP1_LSB +: 5];
         op2_q <= bus.imem_data[OP2_LSB +: 5];
         dec_q <= dec_in;
      end
   end

   // Sticky illegal flag and retired-instruction counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         if (set_illegal) illegal_q <= 1'b1;
         if (commit)      instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign bus.opcode    = opc_q;
   assign bus.op1       = op1_q;
   assign bus.op2       = op2_q;
   assign bus.alucode   = dec_q.alucode;
   assign bus.imControl = dec_q.imm;
   assign bus.writecode = dec_q.wcode;
   assign bus.pcControl = dec_q.pc_ctl;
   assign halted        = (state_q == ST_HALT);
   assign illegal       = illegal_q;
   assign instret       = instret_q;

endmodule

// File: tb/tb_j17_control_unit.sv
// Scoreboard bench for j17_control_unit: memory responders issue instructions
// and push expected commits; a monitor pops and compares on every pc_en pulse.
module tb_j17_control_unit;

   logic        clock = 1'b0;
   logic        resetn;
   logic        run;
   logic        halted;
   logic        illegal;
   logic [31:0] instret;

   j17_if #(.IW(32)) bus ();

   j17_control_unit #(.IW(32), .CNT_W(32)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .run     (run),
      .bus     (bus),
      .halted  (halted),
      .illegal (illegal),
      .instret (instret)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         commits;
      bit         halts;
      bit         illeg;
      bit         is_alu;
      logic [5:0] opc;
      logic [4:0] o1;
      logic [4:0] o2;
      logic [4:0] alu;
      logic       imm;
      logic [1:0] wc;
      logic [2:0] pcc;
      logic       reg_w;
      logic [1:0] ram;
      int         mem_wait;
      int         due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] prog[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int retired = 0;
   int pc_pulses = 0;
   int force_ack = -1;
   int force_mem = -1;
   int ack_cnt = 0;
   int ack_rand = 0;
   int mem_cnt = 0;
   int last_mem_len = 0;
   logic [31:0] rsp_word;
   int          rsp_mw;
   int          rsp_tgt;
   exp_t        rsp_e;
   exp_t        mon_e;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour from the instruction-set rules; latency counted in
   // cycles after the fetch-ack cycle.
   function automatic exp_t model(logic [31:0] ins, int mw);
      exp_t e;
      int   op;
      e          = '{default: 0};
      op         = int'(ins[31:26]);
      e.opc      = ins[31:26];
      e.o1       = ins[25:21];
      e.o2       = ins[20:16];
      e.mem_wait = mw;
      if (op < 32) begin
         if (op % 16 > 11) e.illeg = 1;
         else begin
            e.commits = 1; e.is_alu = 1; e.alu = 5'(op % 16);
            e.imm = (op >= 16); e.reg_w = 1; e.wc = 2'd0; e.due = 2;
         end
      end else if (op < 48) begin
         if (op % 8 == 0) e.illeg = 1;
         else begin
            e.commits = 1; e.pcc = 3'(op % 8); e.due = 2;
         end
      end else if (op == 48) begin
         e.commits = 1; e.reg_w = 1; e.wc = 2'd2; e.ram = 2'b01; e.due = 4 + mw;
      end else if (op == 49) begin
         e.commits = 1; e.ram = 2'b10; e.due = 3 + mw;
      end else if (op == 50) begin
         e.commits = 1; e.reg_w = 1; e.wc = 2'd1; e.due = 2;
      end else if (op == 63) begin
         e.halts = 1;
      end else begin
         e.illeg = 1;
      end
      if (e.illeg) e.halts = 1;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [5:0]  op;
      r = $urandom();
      case ($urandom_range(0, 5))
         0:       op = 6'($urandom_range(0, 11));
         1:       op = 6'(16 + $urandom_range(0, 11));
         2:       op = 6'(32 + 8 * $urandom_range(0, 1) + $urandom_range(1, 7));
         3:       op = 6'h30;
         4:       op = 6'h31;
         default: op = 6'h32;
      endcase
      return {op, r[25:0]};
   endfunction

   always @(posedge clock) cyc++;

   // Instruction-memory and RAM responders; expected commits pushed at fetch ack.
   always @(negedge clock) begin
      bus.imem_ack  = 1'b0;
      bus.mem_ready = 1'b0;
      if (!resetn) begin
         ack_cnt  = 0;
         ack_rand = $urandom_range(0, 3);
         mem_cnt  = 0;
         exp_q.delete();
      end else begin
         rsp_tgt = (force_ack >= 0) ? force_ack : ack_rand;
         if (bus.imem_req) begin
            if (ack_cnt >= rsp_tgt && prog.size() > 0) begin
               rsp_word = prog.pop_front();
               rsp_mw   = (force_mem >= 0) ? force_mem : $urandom_range(0, 3);
               rsp_e    = model(rsp_word, rsp_mw);
               rsp_e.due += cyc;
               if (rsp_e.commits) exp_q.push_back(rsp_e);
               bus.imem_ack  = 1'b1;
               bus.imem_data = rsp_word;
               ack_cnt       = 0;
               ack_rand      = $urandom_range(0, 3);
            end else begin
               ack_cnt++;
            end
         end
         if (bus.ramenable != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("ram_unexpected", 64'(bus.ramenable), 64'd0);
            end else begin
               if (mem_cnt == 0) check("ram_kind", 64'(bus.ramenable), 64'(exp_q[0].ram));
               if (mem_cnt >= exp_q[0].mem_wait) begin
                  bus.mem_ready = 1'b1;
                  last_mem_len  = mem_cnt + 1;
                  mem_cnt       = 0;
               end else begin
                  mem_cnt++;
               end
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   // Commit monitor.
   always @(negedge clock) begin
      #2;
      if (!resetn) begin
         retired   = 0;
         pc_pulses = 0;
      end else if (bus.pc_en) begin
         pc_pulses++;
         if (exp_q.size() == 0) begin
            check("commit_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("opcode", 64'(bus.opcode), 64'(mon_e.opc));
            check("op1", 64'(bus.op1), 64'(mon_e.o1));
            check("op2", 64'(bus.op2), 64'(mon_e.o2));
            check("pcControl", 64'(bus.pcControl), 64'(mon_e.pcc));
            check("regenable", 64'(bus.regenable), 64'(mon_e.reg_w));
            if (mon_e.reg_w) check("writecode", 64'(bus.writecode), 64'(mon_e.wc));
            if (mon_e.is_alu) begin
               check("alucode", 64'(bus.alucode), 64'(mon_e.alu));
               check("imControl", 64'(bus.imControl), 64'(mon_e.imm));
            end
            check("latency", 64'(cyc), 64'(mon_e.due));
            check("instret", 64'(instret), 64'(retired));
            retired++;
         end
      end else begin
         check("regen_outside_commit", 64'(bus.regenable), 64'd0);
      end
   end

   task automatic do_reset();
      resetn    = 1'b0;
      run       = 1'b0;
      force_ack = -1;
      force_mem = -1;
      prog.delete();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic wait_drain(string name, int limit);
      int n = 0;
      while ((prog.size() > 0 || exp_q.size() > 0) && n < limit) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock); #3;
      check(name, 64'(n < limit), 64'd1);
   endtask

   task automatic wait_halted(string name, int limit);
      int n = 0;
      while (!halted && n < limit) begin
         @(negedge clock); #1;
         n++;
      end
      check(name, 64'(halted), 64'd1);
   endtask

   initial begin
      logic [5:0] bad_ops[4];
      int n;
      bad_ops = '{6'h0C, 6'h1F, 6'h28, 6'h35};

      // Reset with run low: nothing moves.
      do_reset();
      repeat (5) begin
         @(negedge clock); #1;
         check("idle_req", 64'(bus.imem_req), 64'd0);
      end
      check("idle_strobes", 64'({bus.pc_en, bus.regenable, bus.ramenable}), 64'd0);
      check("idle_instret", 64'(instret), 64'd0);
      check("idle_flags", 64'({halted, illegal}), 64'd0);

      // ADD r2,r1 with zero-wait fetch.
      do_reset();
      force_ack = 0;
      prog.push_back(32'h0441_0000);
      run = 1'b1;
      wait_drain("add_drain", 50);
      check("add_instret", 64'(instret), 64'd1);

      // LOAD with fetch stalled 2 cycles and RAM ready in its 3rd cycle.
      do_reset();
      force_ack = 2;
      force_mem = 2;
      prog.push_back({6'h30, 5'd3, 5'd4, 16'h0010});
      run = 1'b1;
      wait_drain("load_drain", 60);
      check("load_ram_cycles", 64'(last_mem_len), 64'd3);
      check("load_pc_pulses", 64'(pc_pulses), 64'd1);

      // Branch then illegal branch code 000.
      do_reset();
      prog.push_back({6'h21, 5'd1, 5'd2, 16'h0004});
      prog.push_back({6'h20, 26'h0});
      run = 1'b1;
      wait_drain("branch_drain", 60);
      wait_halted("branch_halt", 20);
      check("branch_illegal", 64'(illegal), 64'd1);
      check("branch_instret", 64'(instret), 64'd1);

      // Assorted illegal opcodes trap without retiring.
      foreach (bad_ops[i]) begin
         do_reset();
         prog.push_back({bad_ops[i], 26'h155_5555});
         run = 1'b1;
         wait_halted("illegal_halt", 30);
         check("illegal_flag", 64'(illegal), 64'd1);
         check("illegal_instret", 64'(instret), 64'd0);
      end

      // run dropped while a STORE waits on RAM.
      do_reset();
      force_ack = 0;
      force_mem = 3;
      prog.push_back({6'h31, 5'd7, 5'd9, 16'h0020});
      run = 1'b1;
      n = 0;
      while (bus.ramenable == 2'b00 && n < 20) begin
         @(negedge clock); #1;
         n++;
      end
      check("store_mem_reached", 64'(n < 20), 64'd1);
      run = 1'b0;
      wait_drain("store_drain", 30);
      repeat (5) begin
         @(negedge clock); #1;
         check("store_no_fetch", 64'(bus.imem_req), 64'd0);
      end
      check("store_instret", 64'(instret), 64'd1);

      // Three ALU instructions then HALT.
      do_reset();
      for (int i = 0; i < 3; i++)
         prog.push_back({6'($urandom_range(0, 11)), 26'($urandom())});
      prog.push_back({6'h3F, 26'h0});
      run = 1'b1;
      wait_drain("halt_drain", 100);
      wait_halted("halt_reached", 20);
      check("halt_illegal", 64'(illegal), 64'd0);
      check("halt_instret", 64'(instret), 64'd3);
      prog.push_back(32'h0441_0000);
      repeat (10) begin
         @(negedge clock); #1;
         check("halt_quiet", 64'({bus.imem_req, bus.pc_en, bus.regenable, bus.ramenable}), 64'd0);
      end

      // Random legal instruction stream with random stalls and run toggling.
      do_reset();
      for (int i = 0; i < 60; i++) prog.push_back(rand_instr());
      n = 0;
      while ((prog.size() > 0 || exp_q.size() > 0) && n < 3000) begin
         run = ($urandom_range(0, 9) != 0);
         @(negedge clock);
         n++;
      end
      run = 1'b1;
      wait_drain("random_drain", 40);
      check("random_instret", 64'(instret), 64'd60);
      check("random_not_halted", 64'(halted), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
